work_feeder: RTL and testbench

WORK_FEEDER -- requirements
Module: work_feeder

---
 rtl/sha256_pkg.sv | 21 ++
 rtl/nonce_tag_pipe.sv | 47 ++++
 rtl/work_feeder.sv | 177 +++++++++++++++++
 tb/tb_work_feeder.sv | 531 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 feeder constants, FSM state type and word helper.
// Imported by the work feeder and its testbench.
package sha256_pkg;

  localparam logic [31:0] PAD_WORD = 32'h8000_0000;
  localparam logic [31:0] LEN_WORD = 32'h0000_0280;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } feeder_state_e;

  // Bit offset of 32-bit word k inside the 512-bit block.
  function automatic logic [8:0] word_lsb(
    input logic [3:0] k
  );
    return {k, 5'd0};
  endfunction

endpackage

// File: rtl/nonce_tag_pipe.sv
// Shift register of {valid, nonce} tags that rides alongside the hash core.
// Ports: clk, rst_n, shift_en, tag_in (33b) -> tag_out (oldest), head_empty.
module nonce_tag_pipe #(
  parameter int N = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        shift_en,
  input  logic [32:0] tag_in,
  output logic [32:0] tag_out,
  output logic        head_empty
);

  logic [32:0] ent_q [N];
  logic [32:0] ent_d [N];

  always_comb begin
    ent_d = ent_q;
    if (shift_en) begin
      ent_d[0] = tag_in;
      for (int i = 1; i < N; i++) begin
        ent_d[i] = ent_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      ent_q <= ent_d;
    end
  end

  assign tag_out = ent_q[N-1];

  // Entries 0..N-2 only: after the next shift these are the whole pipe.
  always_comb begin
    head_empty = 1'b1;
    for (int i = 0; i < N - 1; i++) begin
      if (ent_q[i][32]) head_empty = 1'b0;
    end
  end

endmodule

// File: rtl/work_feeder.sv
// Feeds one mining job (midstate + header tail) into a looped SHA-256 core,
// issuing one nonce per loop slot and tagging each so results line up.
// Ports: work_* handshake in, abort; cnt/feedback/rx_state/rx_input to the
// transform; result_valid/result_nonce aligned to its output; busy, done.
module work_feeder
  import sha256_pkg::*;
#(
  parameter int LOOP = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         work_valid,
  output logic         work_ready,
  input  logic [255:0] work_midstate,
  input  logic [95:0]  work_data,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic         abort,
  output logic [5:0]   cnt,
  output logic         feedback,
  output logic [255:0] rx_state,
  output logic [511:0] rx_input,
  output logic         result_valid,
  output logic [31:0]  result_nonce,
  output logic         busy,
  output logic         done
);

  localparam int N = 64 / LOOP;
  localparam logic [5:0] CNT_LAST = 6'(LOOP - 1);
  localparam logic [5:0] SLOT_LAST = 6'(N - 1);

  feeder_state_e state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [255:0] mid_q, mid_d;
  logic [95:0]  data_q, data_d;
  logic [31:0]  nonce_q, nonce_d;
  logic [31:0]  end_q, end_d;
  logic         loaded_q, loaded_d;
  logic         issued_q, issued_d;
  logic [5:0]   dcnt_q, dcnt_d;
  logic         res_v_q, res_v_d;
  logic [31:0]  res_n_q, res_n_d;
  logic         done_q, done_d;

  logic        slot;
  logic        issue;
  logic        head_empty;
  logic        drain_exit;
  logic [32:0] tag_in;
  logic [32:0] tag_out;

  assign slot   = (cnt_q == 6'd0);
  assign issue  = slot && (state_q == S_RUN);
  assign tag_in = {issue, nonce_q};

  // A job that never issued still waits N empty slots before done.
  assign drain_exit = slot && head_empty &&
                      (issued_q || (dcnt_q == SLOT_LAST));

  nonce_tag_pipe #(
    .N(N)
  ) u_tags (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_en   (slot),
    .tag_in     (tag_in),
    .tag_out    (tag_out),
    .head_empty (head_empty)
  );

  always_comb begin
    state_d  = state_q;
    mid_d    = mid_q;
    data_d   = data_q;
    nonce_d  = nonce_q;
    end_d    = end_q;
    loaded_d = loaded_q;
    issued_d = issued_q;
    dcnt_d   = dcnt_q;
    done_d   = 1'b0;

    cnt_d = (cnt_q == CNT_LAST) ? 6'd0 : cnt_q + 6'd1;

    res_v_d = 1'b0;
    res_n_d = res_n_q;
    if (slot) begin
      res_v_d = tag_out[32];
      res_n_d = tag_out[31:0];
    end

    unique case (state_q)
      S_IDLE: begin
        if (work_valid) begin
          mid_d    = work_midstate;
          data_d   = work_data;
          nonce_d  = nonce_start;
          end_d    = nonce_end;
          loaded_d = 1'b1;
          issued_d = 1'b0;
          dcnt_d   = 6'd0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (issue) begin
          nonce_d  = nonce_q + 32'd1;
          issued_d = 1'b1;
        end
        if ((issue && (nonce_q == end_q)) || abort) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (slot) dcnt_d = dcnt_q + 6'd1;
        if (drain_exit) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mid_q    <= '0;
      data_q   <= '0;
      nonce_q  <= '0;
      end_q    <= '0;
      loaded_q <= 1'b0;
      issued_q <= 1'b0;
      dcnt_q   <= '0;
      res_v_q  <= 1'b0;
      res_n_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mid_q    <= mid_d;
      data_q   <= data_d;
      nonce_q  <= nonce_d;
      end_q    <= end_d;
      loaded_q <= loaded_d;
      issued_q <= issued_d;
      dcnt_q   <= dcnt_d;
      res_v_q  <= res_v_d;
      res_n_q  <= res_n_d;
      done_q   <= done_d;
    end
  end

  // Padding words stay zero until a job has been captured.
  always_comb begin
    rx_input = '0;
    if (loaded_q) begin
      rx_input[word_lsb(4'd0) +: 32]  = data_q[31:0];
      rx_input[word_lsb(4'd1) +: 32]  = data_q[63:32];
      rx_input[word_lsb(4'd2) +: 32]  = data_q[95:64];
      rx_input[word_lsb(4'd3) +: 32]  = nonce_q;
      rx_input[word_lsb(4'd4) +: 32]  = PAD_WORD;
      rx_input[word_lsb(4'd15) +: 32] = LEN_WORD;
    end
  end

  assign cnt          = cnt_q;
  assign feedback     = (cnt_q != 6'd0);
  assign rx_state     = mid_q;
  assign result_valid = res_v_q;
  assign result_nonce = res_n_q;
  assign done         = done_q;
  assign busy         = (state_q != S_IDLE);
  assign work_ready   = (state_q == S_IDLE);

endmodule

// File: tb/tb_work_feeder.sv
// Directed bench for work_feeder: LOOP=4 main instance, LOOP=1 side instance.
// Each scenario task drives stimulus and checks its own expectations.
module tb_work_feeder;

  logic         clk;
  logic         rst_n;

  logic         work_valid;
  logic         work_ready;
  logic [255:0] work_midstate;
  logic [95:0]  work_data;
  logic [31:0]  nonce_start;
  logic [31:0]  nonce_end;
  logic         abort;
  logic [5:0]   cnt;
  logic         feedback;
  logic [255:0] rx_state;
  logic [511:0] rx_input;
  logic         result_valid;
  logic [31:0]  result_nonce;
  logic         busy;
  logic         done;

  logic         w1_valid;
  logic         w1_ready;
  logic [31:0]  w1_start;
  logic [31:0]  w1_end;
  logic         abort1;
  logic [5:0]   cnt1;
  logic         fb1;
  logic [255:0] rx_state1;
  logic [511:0] rx_input1;
  logic         rv1;
  logic [31:0]  rnonce1;
  logic         busy1;
  logic         done1;

  int cyc = 0;
  int rel = 0;
  int n_cmp = 0;
  int n_bad = 0;

  int          rc[$];
  logic [31:0] rn[$];
  int          dc[$];
  int          r1c[$];
  logic [31:0] r1n[$];
  int          d1c[$];

  work_feeder #(.LOOP(4)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .work_valid    (work_valid),
    .work_ready    (work_ready),
    .work_midstate (work_midstate),
    .work_data     (work_data),
    .nonce_start   (nonce_start),
    .nonce_end     (nonce_end),
    .abort         (abort),
    .cnt           (cnt),
    .feedback      (feedback),
    .rx_state      (rx_state),
    .rx_input      (rx_input),
    .result_valid  (result_valid),
    .result_nonce  (result_nonce),
    .busy          (busy),
    .done          (done)
  );

  work_feeder #(.LOOP(1)) u_dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .work_valid    (w1_valid),
    .work_ready    (w1_ready),
    .work_midstate ({8{32'h5A5A_0001}}),
    .work_data     (96'h3_0000_0002_0000_0001),
    .nonce_start   (w1_start),
    .nonce_end     (w1_end),
    .abort         (abort1),
    .cnt           (cnt1),
    .feedback      (fb1),
    .rx_state      (rx_state1),
    .rx_input      (rx_input1),
    .result_valid  (rv1),
    .result_nonce  (rnonce1),
    .busy          (busy1),
    .done          (done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter plus result/done logger, sampled 1 unit after each edge.
  always @(posedge clk) begin
    if (rst_n) cyc = cyc + 1;
    #1;
    if (result_valid === 1'b1) begin
      rc.push_back(cyc);
      rn.push_back(result_nonce);
    end
    if (done === 1'b1) dc.push_back(cyc);
    if (rv1 === 1'b1) begin
      r1c.push_back(cyc);
      r1n.push_back(rnonce1);
    end
    if (done1 === 1'b1) d1c.push_back(cyc);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // First issue edge after capture edge c, for a given loop length.
  function automatic int next_issue(input int c, input int l);
    int e;
    e = c + 1;
    while (((e - rel - 1) % l) != 0) e++;
    return e;
  endfunction

  task automatic clear_q();
    rc.delete();
    rn.delete();
    dc.delete();
    r1c.delete();
    r1n.delete();
    d1c.delete();
  endtask

  task automatic run_job(
    input  logic [255:0] ms,
    input  logic [95:0]  dat,
    input  logic [31:0]  s,
    input  logic [31:0]  e,
    output int           c
  );
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (work_ready === 1'b1) break;
    end
    work_valid    = 1'b1;
    work_midstate = ms;
    work_data     = dat;
    nonce_start   = s;
    nonce_end     = e;
    @(posedge clk);
    #2;
    c = cyc;
    @(negedge clk);
    work_valid = 1'b0;
  endtask

  task automatic wait_done(input int want, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (dc.size() >= want) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #2;
    end
  endtask

  task automatic test_reset(input string nm);
    logic [42:0] got;
    logic [42:0] exp;
    exp = {1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 32'd0, 1'b0};
    got = {busy, work_ready, cnt, feedback,
           result_valid, result_nonce, done};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s_ctrl got %h want %h", nm, got, exp);
    end
    n_cmp++;
    if (rx_state !== 256'd0) begin
      n_bad++;
      $display("FAIL %s_rx_state got %h want 0", nm, rx_state);
    end
    n_cmp++;
    if (rx_input !== 512'd0) begin
      n_bad++;
      $display("FAIL %s_rx_input got %h want 0", nm, rx_input);
    end
    n_cmp++;
    if (rv1 !== 1'b0 || cnt1 !== 6'd0 || fb1 !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_loop1 got rv=%b cnt=%0d fb=%b want 0",
               nm, rv1, cnt1, fb1);
    end
  endtask

  task automatic test_cnt();
    int m;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      #2;
      m = (cyc - rel) % 4;
      n_cmp++;
      if (cnt !== 6'(m) || feedback !== (m != 0)) begin
        n_bad++;
        $display("FAIL cnt got %0d/%b want %0d/%b",
                 cnt, feedback, m, (m != 0));
      end
    end
  endtask

  task automatic test_sequence(
    input string       nm,
    input logic [31:0] s,
    input logic [31:0] e,
    input int          nexp
  );
    int c;
    int e1;
    int want_c;
    bit ok;
    logic [31:0] want_n;
    clear_q();
    run_job({8{32'hA5A5_1234}}, 96'h1_0000_0002_0000_0003, s, e, c);
    e1 = next_issue(c, 4);
    wait_done(1, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s_done got timeout want pulse", nm);
    end
    repeat (2) @(posedge clk);
    #2;
    n_cmp++;
    if (rn.size() !== nexp) begin
      n_bad++;
      $display("FAIL %s_count got %0d want %0d", nm, rn.size(), nexp);
    end
    for (int i = 0; i < nexp && i < rn.size(); i++) begin
      want_n = s + 32'(i);
      want_c = e1 + 64 + 4 * i;
      n_cmp++;
      if (rn[i] !== want_n || rc[i] !== want_c) begin
        n_bad++;
        $display("FAIL %s_res%0d got %h@%0d want %h@%0d",
                 nm, i, rn[i], rc[i], want_n, want_c);
      end
    end
    want_c = e1 + 64 + 4 * (nexp - 1);
    n_cmp++;
    if (dc.size() !== 1 || dc[0] !== want_c) begin
      n_bad++;
      $display("FAIL %s_done_time got n=%0d want one @%0d",
               nm, dc.size(), want_c);
    end
  endtask

  task automatic test_abort();
    int c;
    int e1;
    bit ok;
    clear_q();
    @(negedge clk);
    abort = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (busy !== 1'b0 || work_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_idle got busy=%b ready=%b want 0/1",
               busy, work_ready);
    end
    @(negedge clk);
    abort = 1'b0;
    run_job({8{32'h0F0F_0F0F}}, 96'h0, 32'h0, 32'h0000_FFFF, c);
    e1 = next_issue(c, 4);
    for (int k = 0; k < 50; k++) begin
      if (cyc >= e1 + 4) break;
      @(posedge clk);
      #2;
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(1, ok);
    repeat (2) @(posedge clk);
    #2;
    n_cmp++;
    if (!ok || rn.size() !== 2) begin
      n_bad++;
      $display("FAIL abort_count got %0d results want 2", rn.size());
    end
    for (int i = 0; i < 2 && i < rn.size(); i++) begin
      n_cmp++;
      if (rn[i] !== 32'(i) || rc[i] !== e1 + 64 + 4 * i) begin
        n_bad++;
        $display("FAIL abort_res%0d got %h@%0d want %h@%0d",
                 i, rn[i], rc[i], i, e1 + 64 + 4 * i);
      end
    end
    n_cmp++;
    if (dc.size() !== 1 || dc[0] !== e1 + 68 || work_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_done got n=%0d ready=%b want one @%0d ready=1",
               dc.size(), work_ready, e1 + 68);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] ma;
    logic [255:0] mb;
    int c;
    int e1;
    int da;
    int eb;
    bit ok;
    ma = {8{32'h1111_AAAA}};
    mb = {8{32'h2222_BBBB}};
    clear_q();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (work_ready === 1'b1) break;
    end
    work_valid    = 1'b1;
    work_midstate = ma;
    work_data     = 96'h0;
    nonce_start   = 32'h100;
    nonce_end     = 32'h101;
    @(posedge clk);
    #2;
    c = cyc;
    @(negedge clk);
    work_midstate = mb;
    nonce_start   = 32'h200;
    nonce_end     = 32'h200;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #2;
      n_cmp++;
      if (work_ready !== 1'b0 || rx_state !== ma) begin
        n_bad++;
        $display("FAIL b2b_hold got ready=%b state=%h want 0/%h",
                 work_ready, rx_state, ma);
      end
    end
    e1 = next_issue(c, 4);
    da = e1 + 68;
    wait_done(1, ok);
    @(posedge clk);
    #2;
    n_cmp++;
    if (rx_state !== mb || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_accept got state=%h busy=%b want %h/1",
               rx_state, busy, mb);
    end
    @(negedge clk);
    work_valid = 1'b0;
    eb = next_issue(da + 1, 4) + 64;
    wait_done(2, ok);
    repeat (2) @(posedge clk);
    #2;
    n_cmp++;
    if (rn.size() !== 3 || rn[0] !== 32'h100 || rn[1] !== 32'h101 ||
        rn[2] !== 32'h200 || rc[1] !== da) begin
      n_bad++;
      $display("FAIL b2b_results got n=%0d %h %h %h want 100 101 200",
               rn.size(), rn[0], rn[1], rn[2]);
    end
    n_cmp++;
    if (rc.size() < 3 || rc[2] !== eb || dc.size() !== 2 ||
        dc[0] !== da || dc[1] !== eb) begin
      n_bad++;
      $display("FAIL b2b_timing got b@%0d done@%0d,%0d want %0d/%0d,%0d",
               rc[2], dc[0], dc[1], eb, da, eb);
    end
  endtask

  task automatic test_rx_input();
    logic [31:0] wx [16];
    logic [31:0] got;
    logic [255:0] ms;
    int c;
    bit ok;
    ms = {8{32'hCAFE_F00D}};
    for (int k = 0; k < 16; k++) wx[k] = 32'h0;
    wx[0]  = 32'hA;
    wx[1]  = 32'hB;
    wx[2]  = 32'hC;
    wx[3]  = 32'hDEAD_BEEF;
    wx[4]  = 32'h8000_0000;
    wx[15] = 32'h0000_0280;
    clear_q();
    run_job(ms, {32'hC, 32'hB, 32'hA}, 32'hDEAD_BEEF, 32'hDEAD_BEEF, c);
    for (int k = 0; k < 16; k++) begin
      got = rx_input[32 * k +: 32];
      n_cmp++;
      if (got !== wx[k]) begin
        n_bad++;
        $display("FAIL rx_w%0d got %h want %h", k, got, wx[k]);
      end
    end
    n_cmp++;
    if (rx_state !== ms) begin
      n_bad++;
      $display("FAIL rx_state got %h want %h", rx_state, ms);
    end
    wait_done(1, ok);
    n_cmp++;
    if (!ok || rn.size() !== 1 || rn[0] !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL rx_result got n=%0d %h want 1 deadbeef",
               rn.size(), rn[0]);
    end
  endtask

  task automatic test_loop1();
    int c;
    clear_q();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (w1_ready === 1'b1) break;
    end
    w1_valid = 1'b1;
    w1_start = 32'h7;
    w1_end   = 32'h9;
    @(posedge clk);
    #2;
    c = cyc;
    @(negedge clk);
    w1_valid = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      #2;
      n_cmp++;
      if (cnt1 !== 6'd0 || fb1 !== 1'b0) begin
        n_bad++;
        $display("FAIL loop1_cnt got %0d/%b want 0/0", cnt1, fb1);
      end
    end
    n_cmp++;
    if (r1n.size() !== 3) begin
      n_bad++;
      $display("FAIL loop1_count got %0d want 3", r1n.size());
    end
    for (int i = 0; i < 3 && i < r1n.size(); i++) begin
      n_cmp++;
      if (r1n[i] !== 32'(7 + i) || r1c[i] !== c + 65 + i) begin
        n_bad++;
        $display("FAIL loop1_res%0d got %h@%0d want %h@%0d",
                 i, r1n[i], r1c[i], 7 + i, c + 65 + i);
      end
    end
    n_cmp++;
    if (d1c.size() !== 1 || d1c[0] !== c + 67) begin
      n_bad++;
      $display("FAIL loop1_done got n=%0d want one @%0d",
               d1c.size(), c + 67);
    end
  endtask

  task automatic test_reset_mid_drain();
    int c;
    int e1;
    clear_q();
    run_job({8{32'h7777_3333}}, 96'h9_0000_0008_0000_0007,
            32'h50, 32'h53, c);
    e1 = next_issue(c, 4);
    for (int k = 0; k < 100; k++) begin
      if (cyc >= e1 + 20) break;
      @(posedge clk);
      #2;
    end
    n_cmp++;
    if (busy !== 1'b1 || work_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_busy got busy=%b ready=%b want 1/0",
               busy, work_ready);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    test_reset("mid_drain");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    clear_q();
    repeat (100) @(posedge clk);
    #2;
    n_cmp++;
    if (rn.size() !== 0 || dc.size() !== 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset got res=%0d done=%0d busy=%b want 0/0/0",
               rn.size(), dc.size(), busy);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    work_valid    = 1'b0;
    work_midstate = '0;
    work_data     = '0;
    nonce_start   = '0;
    nonce_end     = '0;
    abort         = 1'b0;
    w1_valid      = 1'b0;
    w1_start      = '0;
    w1_end        = '0;
    abort1        = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    test_reset("por");
    @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    test_cnt();
    test_sequence("seq", 32'h10, 32'h12, 3);
    test_sequence("wrap", 32'hFFFF_FFFE, 32'h1, 4);
    test_abort();
    test_back_to_back();
    test_rx_input();
    test_loop1();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
